// File: rtl/simple_bus_mem_slave_if.sv
// Simple valid/ready bus between a bus driver (master) and a memory target (slave).
interface simple_bus_mem_slave_if;
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic [15:0] txn_cnt;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rdata, txn_cnt
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rdata, txn_cnt
    );
endinterface

// File: rtl/simple_bus_mem_slave.sv
// Word-addressed memory target for the simple bus. Captures one request,
// waits WAIT_CYCLES, then completes with a one-cycle ready pulse.
module simple_bus_mem_slave #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] OOR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    simple_bus_mem_slave_if.slave bus
);

    localparam int          AW   = $clog2(DEPTH);
    // Byte span of the array, kept 33 bits wide so a 4 GiB window cannot overflow.
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic           in_range_q, in_range_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [15:0]    txn_cnt_q, txn_cnt_d;
    logic [31:0]    rdata_q;
    logic           mem_we;

    logic [31:0]    mem_q [DEPTH];

    // Decode of the live bus address; only consulted on the capture edge.
    logic [31:0]    req_off;
    logic           req_in_range;
    logic [AW-1:0]  req_idx;

    assign req_off      = bus.addr - BASE_ADDR;
    assign req_in_range = ({1'b0, req_off} < SPAN);
    assign req_idx      = req_off[AW+1:2];

    // Next-state, payload capture and commit decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;
        wdata_d    = wdata_q;
        txn_cnt_d  = txn_cnt_q;
        mem_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.valid) begin
                    we_d       = bus.we;
                    idx_d      = req_idx;
                    in_range_d = req_in_range;
                    wdata_d    = bus.wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.valid) begin
                    // Master gave up: drop the request silently.
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (bus.valid) begin
                    txn_cnt_d = txn_cnt_q + 16'd1;
                    mem_we    = we_q && in_range_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            wdata_q    <= 32'd0;
            txn_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            wdata_q    <= wdata_d;
            txn_cnt_q  <= txn_cnt_d;
        end
    end

    // Array write port: commits only on the completing ACK edge, never under reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Registered read port: loaded on entry to ACK, zero in every other cycle.
    // Reads and writes never share an edge since ACK always leaves to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (state_d == ST_ACK && !we_d) begin
            rdata_q <= in_range_d ? mem_q[idx_d] : OOR_RDATA;
        end else begin
            rdata_q <= 32'd0;
        end
    end

    assign bus.ready   = (state_q == ST_ACK);
    assign bus.rdata   = rdata_q;
    assign bus.txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_simple_bus_mem_slave.sv
// Directed bench: dut0 uses defaults (WAIT_CYCLES=2), dut1 has no wait states,
// DEPTH=16 and BASE_ADDR=0x1000.
module tb_simple_bus_mem_slave;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    simple_bus_mem_slave_if b0 ();
    simple_bus_mem_slave_if b1 ();

    simple_bus_mem_slave dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    simple_bus_mem_slave #(
        .DEPTH       (16),
        .WAIT_CYCLES (0),
        .BASE_ADDR   (32'h0000_1000),
        .OOR_RDATA   (32'hDEAD_BEEF)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          sel;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit v, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            b1.valid = v; b1.we = w; b1.addr = a; b1.wdata = d;
        end else begin
            b0.valid = v; b0.we = w; b0.addr = a; b0.wdata = d;
        end
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? b1.ready : b0.ready;
    endfunction

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? b1.rdata : b0.rdata;
    endfunction

    function automatic logic [15:0] get_cnt(input bit sel);
        return sel ? b1.txn_cnt : b0.txn_cnt;
    endfunction

    // Raise valid, wait for ready (bounded), return data seen with ready,
    // then complete the transfer and drop valid.
    task automatic do_txn(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat,
                          output logic rdy_after, output logic [31:0] rd_after);
        drive(sel, 1'b1, w, a, d);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (get_ready(sel)) begin
                lat = i;
                break;
            end
        end
        rd = get_rdata(sel);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        rdy_after = get_ready(sel);
        rd_after  = get_rdata(sel);
        $display("txn dut%0d %s addr=%h wdata=%h rdata=%h lat=%0d cnt=%0d",
                 sel, w ? "WR" : "RD", a, d, rd, lat, get_cnt(sel));
    endtask

    task automatic simple_txn(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_rd, input logic [15:0] exp_cnt, input string name);
        logic [31:0] rd, rd_after;
        logic        rdy_after;
        int          lat;
        do_txn(sel, w, a, d, rd, lat, rdy_after, rd_after);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_cnt"}, 32'(get_cnt(sel)), 32'(exp_cnt));
    endtask

    // Hold a read request continuously; ready must appear once every 'period' cycles.
    task automatic b2b(input bit sel, input logic [31:0] a, input int ncyc, input int period,
                       input logic [31:0] exp_rd);
        int pulses = 0;
        drive(sel, 1'b1, 1'b0, a, 32'd0);
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2b%0d_ready_c%0d", sel, i), 32'(get_ready(sel)),
                  32'((i % period) == (period - 1)));
            if (get_ready(sel)) begin
                pulses++;
                check($sformatf("b2b%0d_rdata_c%0d", sel, i), get_rdata(sel), exp_rd);
            end
        end
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        $display("b2b dut%0d addr=%h cycles=%0d pulses=%0d cnt=%0d", sel, a, ncyc, pulses, get_cnt(sel));
    endtask

    initial begin
        logic [31:0] rd, rd_after;
        logic        rdy_after;
        int          lat;
        int          seen;
        logic [15:0] cnt_before;

        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        vecs[0]  = '{0, 1, 32'h0000_0000, 32'h0000_CAFE, 32'h0,         3, 16'd1};
        vecs[1]  = '{0, 1, 32'h0000_0010, 32'hA5A5_0001, 32'h0,         3, 16'd2};
        vecs[2]  = '{0, 0, 32'h0000_0010, 32'h0,         32'hA5A5_0001, 3, 16'd3};
        vecs[3]  = '{0, 0, 32'h0000_0400, 32'h0,         32'hDEAD_BEEF, 3, 16'd4};
        vecs[4]  = '{0, 1, 32'h0000_0400, 32'h1111_2222, 32'h0,         3, 16'd5};
        vecs[5]  = '{0, 0, 32'h0000_0000, 32'h0,         32'h0000_CAFE, 3, 16'd6};
        vecs[6]  = '{0, 0, 32'h0000_0013, 32'h0,         32'hA5A5_0001, 3, 16'd7};
        vecs[7]  = '{0, 1, 32'h0000_03FC, 32'hFFFF_0000, 32'h0,         3, 16'd8};
        vecs[8]  = '{0, 0, 32'h0000_03FC, 32'h0,         32'hFFFF_0000, 3, 16'd9};
        vecs[9]  = '{0, 0, 32'hFFFF_FFFC, 32'h0,         32'hDEAD_BEEF, 3, 16'd10};
        vecs[10] = '{1, 1, 32'h0000_1004, 32'h0000_1004, 32'h0,         1, 16'd1};
        vecs[11] = '{1, 0, 32'h0000_1004, 32'h0,         32'h0000_1004, 1, 16'd2};
        vecs[12] = '{1, 0, 32'h0000_1040, 32'h0,         32'hDEAD_BEEF, 1, 16'd3};
        vecs[13] = '{1, 0, 32'h0000_0FFC, 32'h0,         32'hDEAD_BEEF, 1, 16'd4};
        vecs[14] = '{1, 1, 32'h0000_103C, 32'h0000_3C3C, 32'h0,         1, 16'd5};
        vecs[15] = '{1, 0, 32'h0000_103C, 32'h0,         32'h0000_3C3C, 1, 16'd6};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(b0.ready), 32'd0);
        check("rst_rdata", b0.rdata, 32'd0);
        check("rst_cnt", 32'(b0.txn_cnt), 32'd0);
        check("rst_cnt1", 32'(b1.txn_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of complete transfers on both instances
        for (int k = 0; k < 16; k++) begin
            do_txn(vecs[k].sel, vecs[k].we, vecs[k].addr, vecs[k].wdata, rd, lat, rdy_after, rd_after);
            check($sformatf("v%0d_lat", k), 32'(lat), 32'(vecs[k].exp_lat));
            check($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rdata);
            check($sformatf("v%0d_ready_after", k), 32'(rdy_after), 32'd0);
            check($sformatf("v%0d_rdata_after", k), rd_after, 32'd0);
            check($sformatf("v%0d_cnt", k), 32'(get_cnt(vecs[k].sel)), 32'(vecs[k].exp_cnt));
        end

        // Abort in WAIT: no pulse, no write, no count
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h9999_9999);
        repeat (2) begin @(posedge clk); #1; end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        seen = 0;
        repeat (5) begin @(posedge clk); #1; if (b0.ready) seen++; end
        $display("abort in WAIT addr=%h pulses=%0d cnt=%0d", 32'h10, seen, b0.txn_cnt);
        check("abort_pulses", 32'(seen), 32'd0);
        check("abort_cnt", 32'(b0.txn_cnt), 32'd10);
        simple_txn(1'b0, 1'b0, 32'h10, 32'd0, 32'hA5A5_0001, 16'd11, "abort_rd");

        // Abandon in ACK: valid low on the ACK edge
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h7777_7777);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (b0.ready) begin seen = 1; break; end
        end
        check("abandon_seen", 32'(seen), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        $display("abandon in ACK addr=%h ready=%0d cnt=%0d", 32'h10, b0.ready, b0.txn_cnt);
        check("abandon_ready", 32'(b0.ready), 32'd0);
        check("abandon_cnt", 32'(b0.txn_cnt), 32'd11);
        simple_txn(1'b0, 1'b0, 32'h10, 32'd0, 32'hA5A5_0001, 16'd12, "abandon_rd");

        // Payload changes after capture are ignored
        simple_txn(1'b0, 1'b1, 32'h40, 32'h4040_4040, 32'd0, 16'd13, "pre40_wr");
        drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h3030_3030);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'hBAD0_BAD0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (b0.ready) begin seen = 1; break; end
        end
        check("capture_seen", 32'(seen), 32'd1);
        check("capture_rdata", b0.rdata, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        $display("capture-then-change txn cnt=%0d", b0.txn_cnt);
        check("capture_cnt", 32'(b0.txn_cnt), 32'd14);
        simple_txn(1'b0, 1'b0, 32'h30, 32'd0, 32'h3030_3030, 16'd15, "cap30_rd");
        simple_txn(1'b0, 1'b0, 32'h40, 32'd0, 32'h4040_4040, 16'd16, "cap40_rd");

        // Back-to-back with valid held
        b2b(1'b0, 32'h30, 14, 4, 32'h3030_3030);
        repeat (2) begin @(posedge clk); #1; end
        check("b2b0_cnt", 32'(b0.txn_cnt), 32'd19);
        b2b(1'b1, 32'h1004, 8, 2, 32'h0000_1004);
        @(posedge clk); #1;
        check("b2b1_cnt", 32'(b1.txn_cnt), 32'd10);

        // Reset during ACK of a write
        simple_txn(1'b0, 1'b1, 32'h20, 32'h2020_2020, 32'd0, 16'd20, "pre20_wr");
        cnt_before = b0.txn_cnt;
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hBADB_AD00);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (b0.ready) begin seen = 1; break; end
        end
        check("rstack_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        $display("reset in ACK cnt_before=%0d ready=%0d cnt=%0d", cnt_before, b0.ready, b0.txn_cnt);
        check("rstack_ready", 32'(b0.ready), 32'd0);
        check("rstack_cnt", 32'(b0.txn_cnt), 32'd0);
        check("rstack_rdata", b0.rdata, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        simple_txn(1'b0, 1'b0, 32'h20, 32'd0, 32'h2020_2020, 16'd1, "rstack_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
